// File: rtl/jtbubl_sndcomm.sv
// Sound-CPU side of the main<->sound mailbox: command queue, NMI generator and reply latch.
// Define JTBUBL_SNDFIFO_EN for a 4-entry command FIFO; otherwise a single byte latch is used.
module jtbubl_sndcomm #(
    parameter int NMI_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen3,
    input  logic [7:0] snd_latch,
    input  logic       snd_stb,
    output logic       snd_flag,
    input  logic       main_ack,
    output logic [7:0] main_latch,
    output logic       main_stb,
    output logic       main_flag,
    input  logic       cpu_cs,
    input  logic       cpu_rnw,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_dout,
    output logic [7:0] cpu_din,
    output logic       nmi_n
);

    typedef enum logic {IDLE, PULSE} state_t;

    state_t     state, state_nx;
    logic [7:0] nmi_cnt, nmi_cnt_nx;
    logic       stb_l, ack_l;
    logic       pushed, nmi_en, ovf;
    logic       acc, rd0, rd1, wr0, wr1, wr2;
    logic       push, pop, push_ok, drop, ack_edge, empty;
    logic [7:0] head;

    assign acc      = cpu_cs & cen3;
    assign rd0      = acc &  cpu_rnw & (cpu_addr == 2'd0);
    assign rd1      = acc &  cpu_rnw & (cpu_addr == 2'd1);
    assign wr0      = acc & ~cpu_rnw & (cpu_addr == 2'd0);
    assign wr1      = acc & ~cpu_rnw & (cpu_addr == 2'd1);
    assign wr2      = acc & ~cpu_rnw & (cpu_addr == 2'd2);
    assign push     = snd_stb & ~stb_l;
    assign ack_edge = main_ack & ~ack_l;

    // Edge-detector history follows the inputs even through reset
    always_ff @(posedge clk) begin
        stb_l <= snd_stb;
        ack_l <= main_ack;
    end

`ifdef JTBUBL_SNDFIFO_EN
    logic [7:0] fifo [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] cnt;

    assign empty   = (cnt == 3'd0);
    assign head    = fifo[rd_ptr];
    assign pop     = rd0 & ~empty;
    assign push_ok = push & (cnt != 3'd4);
    assign drop    = push & (cnt == 3'd4);

    always_ff @(posedge clk) begin
        if (push_ok) fifo[wr_ptr] <= snd_latch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            cnt    <= 3'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end
`else
    logic [7:0] latch;
    logic       valid;

    assign empty   = ~valid;
    assign head    = latch;
    assign pop     = rd0 & valid;
    assign push_ok = push;
    // Overwriting a byte that is not being read in this same cycle loses it
    assign drop    = push & valid & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            latch <= 8'h00;
            valid <= 1'b0;
        end else if (push) begin
            latch <= snd_latch;
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end
`endif

    assign snd_flag = ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            pushed     <= 1'b0;
            ovf        <= 1'b0;
            nmi_en     <= 1'b1;
            main_latch <= 8'h00;
            main_stb   <= 1'b0;
            main_flag  <= 1'b0;
        end else begin
            pushed   <= push_ok;
            main_stb <= wr0;
            if (drop)     ovf <= 1'b1;
            else if (rd1) ovf <= 1'b0;
            if (wr1) nmi_en <= cpu_dout[0];
            if (wr0) begin
                main_latch <= cpu_dout;
                main_flag  <= 1'b1;
            end else if (ack_edge) begin
                main_flag  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            nmi_cnt <= 8'd0;
        end else begin
            state   <= state_nx;
            nmi_cnt <= nmi_cnt_nx;
        end
    end

    // Pulse length counts cen3 pulses seen while in PULSE; leaves on the last one
    always_comb begin
        state_nx   = state;
        nmi_cnt_nx = nmi_cnt;
        case (state)
            IDLE: begin
                if (pushed && nmi_en) begin
                    state_nx   = PULSE;
                    nmi_cnt_nx = 8'(NMI_LEN);
                end
            end
            PULSE: begin
                if (wr2) begin
                    state_nx   = IDLE;
                    nmi_cnt_nx = 8'd0;
                end else if (cen3) begin
                    nmi_cnt_nx = nmi_cnt - 8'd1;
                    if (nmi_cnt <= 8'd1) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign nmi_n = (state != PULSE);

    always_comb begin
        cpu_din = 8'hFF;
        case (cpu_addr)
            2'd0:    if (!empty) cpu_din = head;
            2'd1:    cpu_din = {5'b0, ovf, main_flag, snd_flag};
            default: cpu_din = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_jtbubl_sndcomm.sv
// Scoreboard bench for jtbubl_sndcomm: directed test-plan sequences followed by random traffic.
module tb_jtbubl_sndcomm;
    localparam int NMI_LEN = 8;

    logic       clk = 1'b0;
    logic       rst, cen3, snd_stb, main_ack, cpu_cs, cpu_rnw;
    logic [7:0] snd_latch, cpu_dout;
    logic [1:0] cpu_addr;
    logic       snd_flag, main_stb, main_flag, nmi_n;
    logic [7:0] main_latch, cpu_din;

    jtbubl_sndcomm #(.NMI_LEN(NMI_LEN)) dut (
        .clk(clk), .rst(rst), .cen3(cen3),
        .snd_latch(snd_latch), .snd_stb(snd_stb), .snd_flag(snd_flag),
        .main_ack(main_ack), .main_latch(main_latch), .main_stb(main_stb), .main_flag(main_flag),
        .cpu_cs(cpu_cs), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .nmi_n(nmi_n)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    bit rand_mode = 0, mon_en = 0;

    // bench-side input values, applied after each rising edge
    logic       b_rst = 1, b_cen3 = 0, b_stb = 0, b_ack = 0, b_cs = 0, b_rnw = 1;
    logic [7:0] b_lat = 0, b_dout = 0;
    logic [1:0] b_addr = 0;

    // reference model state
    logic [7:0] mq[$];
    logic [7:0] rd_q[$], rep_q[$];
    bit         m_ovf = 0, m_mflag = 0, m_mstb = 0, m_nmi_en = 1, m_nmi_on = 0, m_trig = 0;
    bit         m_stb_prev = 0, m_ack_prev = 0;
    int         m_left = 0;
    logic [7:0] m_mlatch = 8'h00;
    logic       e_snd_flag, e_mflag, e_mstb, e_nmi_n;
    logic [7:0] e_mlatch;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic predict();
        bit acc, push, pop, store;
        int n;
        logic [7:0] exp;
        e_snd_flag = (mq.size() > 0);
        e_mflag    = m_mflag;
        e_mstb     = m_mstb;
        e_nmi_n    = !m_nmi_on;
        e_mlatch   = m_mlatch;
        acc = cpu_cs && cen3;
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_mflag = 0; m_mstb = 0; m_nmi_en = 1; m_nmi_on = 0;
            m_trig = 0; m_left = 0; m_mlatch = 8'h00;
        end else begin
            n = mq.size();
            if (acc && cpu_rnw) begin
                case (cpu_addr)
                    2'd0:    exp = (n > 0) ? mq[0] : 8'hFF;
                    2'd1:    exp = {5'b0, m_ovf, m_mflag, n > 0};
                    default: exp = 8'hFF;
                endcase
                rd_q.push_back(exp);
            end
            push = snd_stb && !m_stb_prev;
            pop  = acc && cpu_rnw && cpu_addr == 2'd0 && n > 0;
            if (acc && cpu_rnw && cpu_addr == 2'd1) m_ovf = 0;
            if (pop) void'(mq.pop_front());
            store = 0;
`ifdef JTBUBL_SNDFIFO_EN
            if (push) begin
                if (n == 4) m_ovf = 1;
                else begin mq.push_back(snd_latch); store = 1; end
            end
`else
            if (push) begin
                if (n == 1 && !pop) m_ovf = 1;
                mq.delete();
                mq.push_back(snd_latch);
                store = 1;
            end
`endif
            if (m_nmi_on) begin
                if (acc && !cpu_rnw && cpu_addr == 2'd2) m_nmi_on = 0;
                else if (cen3) begin
                    m_left--;
                    if (m_left == 0) m_nmi_on = 0;
                end
            end else if (m_trig && m_nmi_en) begin
                m_nmi_on = 1;
                m_left   = NMI_LEN;
            end
            m_trig = store;
            if (acc && !cpu_rnw && cpu_addr == 2'd1) m_nmi_en = cpu_dout[0];
            m_mstb = 0;
            if (acc && !cpu_rnw && cpu_addr == 2'd0) begin
                m_mlatch = cpu_dout; m_mflag = 1; m_mstb = 1;
                rep_q.push_back(cpu_dout);
            end else if (main_ack && !m_ack_prev) m_mflag = 0;
        end
        m_stb_prev = snd_stb;
        m_ack_prev = main_ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rand_mode && !b_cs) b_cen3 = (cyc % 8 == 0);
        rst = b_rst; cen3 = b_cen3; snd_stb = b_stb; snd_latch = b_lat; main_ack = b_ack;
        cpu_cs = b_cs; cpu_rnw = b_rnw; cpu_addr = b_addr; cpu_dout = b_dout;
        predict();
        mon_en = 1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cpu_acc(input logic rnw, input logic [1:0] a, input logic [7:0] d);
        b_cs = 1; b_cen3 = 1; b_rnw = rnw; b_addr = a; b_dout = d;
        tick();
        b_cs = 0; b_rnw = 1;
    endtask

    task automatic send(input logic [7:0] v);
        b_stb = 1; b_lat = v; tick();
        b_stb = 0; tick();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("snd_flag", {7'b0, snd_flag}, {7'b0, e_snd_flag});
            chk("main_flag", {7'b0, main_flag}, {7'b0, e_mflag});
            chk("main_stb", {7'b0, main_stb}, {7'b0, e_mstb});
            chk("nmi_n", {7'b0, nmi_n}, {7'b0, e_nmi_n});
            chk("main_latch", main_latch, e_mlatch);
            if (cpu_cs && cen3 && cpu_rnw && !rst) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cpu_din: read with no expectation, got %h", cpu_din);
                end else chk("cpu_din", cpu_din, rd_q.pop_front());
            end
            if (main_stb) begin
                if (rep_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL reply: unexpected main_stb, latch %h", main_latch);
                end else chk("reply", main_latch, rep_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1; cen3 = 0; snd_stb = 0; snd_latch = 0; main_ack = 0;
        cpu_cs = 0; cpu_rnw = 1; cpu_addr = 0; cpu_dout = 0;
        idle(3);
        b_rst = 0;
        idle(2);
        cpu_acc(1, 2'd1, 8'h00);
        // single command and NMI pulse
        send(8'h5A);
        idle(80);
        cpu_acc(1, 2'd0, 8'h00);
        cpu_acc(1, 2'd0, 8'h00);
        idle(4);
        // overflow
        for (int i = 1; i <= 5; i++) send(8'(i));
        idle(70);
        cpu_acc(1, 2'd1, 8'h00);
        for (int i = 0; i < 5; i++) cpu_acc(1, 2'd0, 8'h00);
        cpu_acc(1, 2'd1, 8'h00);
        // reply path
        cpu_acc(0, 2'd0, 8'hC3);
        idle(3);
        b_ack = 1; tick(); b_ack = 0; idle(2);
        cpu_acc(1, 2'd1, 8'h00);
        b_ack = 1; cpu_acc(0, 2'd0, 8'h3C); b_ack = 0;
        idle(2);
        cpu_acc(1, 2'd1, 8'h00);
        // NMI disable, then early acknowledge
        cpu_acc(0, 2'd1, 8'h00);
        send(8'h11);
        idle(20);
        cpu_acc(1, 2'd0, 8'h00);
        cpu_acc(0, 2'd1, 8'h01);
        send(8'h22);
        idle(12);
        cpu_acc(0, 2'd2, 8'h00);
        idle(4);
        cpu_acc(1, 2'd0, 8'h00);
        // push and pop in the same clock
        send(8'hA1);
        send(8'hA2);
        b_stb = 1; b_lat = 8'hA3; cpu_acc(1, 2'd0, 8'h00); b_stb = 0;
        idle(2);
        cpu_acc(1, 2'd1, 8'h00);
        for (int i = 0; i < 3; i++) cpu_acc(1, 2'd0, 8'h00);
        // reset during a pulse
        send(8'h77);
        idle(6);
        b_rst = 1; tick(); b_rst = 0;
        idle(3);
        cpu_acc(1, 2'd1, 8'h00);
        // random traffic
        rand_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            b_rst  = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 3) == 0) b_stb = ~b_stb;
            if ($urandom_range(0, 5) == 0) b_ack = ~b_ack;
            b_lat  = 8'($urandom);
            b_cs   = ($urandom_range(0, 2) == 0);
            b_rnw  = 1'($urandom);
            b_addr = 2'($urandom);
            b_dout = 8'($urandom);
            b_cen3 = ($urandom_range(0, 3) == 0);
            tick();
        end
        b_rst = 0; b_cs = 0; b_cen3 = 0;
        tick(); tick();
        mon_en = 0;
        chk("rd_q_drained", 8'(rd_q.size()), 8'd0);
        chk("rep_q_drained", 8'(rep_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
